// File: rtl/shift_acc_pkg.sv
// Shared definitions for the shift-accumulate unit: FSM state codes,
// the default accumulator width and a constant-foldable clog2 helper.
package shift_acc_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ACCUM = 2'd1;
   localparam state_t ST_HOLD  = 2'd2;

   localparam int ACC_WIDTH_DEFAULT = 36;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/nibble_shifter.sv
// Combinational left shift of a zero-extended alphabet multiple by
// nib_idx*NIBBLE_WIDTH + sl, producing an accumulator-width term.
module nibble_shifter
   import shift_acc_pkg::*;
#(
   parameter int IX_WIDTH     = 19,
   parameter int IDX_WIDTH    = 3,
   parameter int SL_WIDTH     = 2,
   parameter int NIBBLE_WIDTH = 4,
   parameter int OUT_WIDTH    = 36
) (
   input  logic [IX_WIDTH-1:0]  ix,
   input  logic [IDX_WIDTH-1:0] nib_idx,
   input  logic [SL_WIDTH-1:0]  sl,
   output logic [OUT_WIDTH-1:0] shifted
);

   localparam int SHAMT_WIDTH = clog2(OUT_WIDTH) + 1;

   logic [SHAMT_WIDTH-1:0] shamt;

   always_comb begin
      shamt   = SHAMT_WIDTH'(nib_idx) * SHAMT_WIDTH'(NIBBLE_WIDTH) + SHAMT_WIDTH'(sl);
      shifted = {{(OUT_WIDTH-IX_WIDTH){1'b0}}, ix} << shamt;
   end

endmodule

// File: rtl/shift_acc_unit.sv
// Accumulates up to NUM_NIBBLES shifted partial-product beats and presents
// the two's-complement sum on a valid/ready result port.
module shift_acc_unit
   import shift_acc_pkg::*;
#(
   parameter int LOG2_WIDTH        = 4,
   parameter int WIDTH             = 2**LOG2_WIDTH,
   parameter int LOG2_NIBBLE_WIDTH = 2,
   parameter int NIBBLE_WIDTH      = 2**LOG2_NIBBLE_WIDTH,
   parameter int NUM_NIBBLES       = WIDTH/NIBBLE_WIDTH,
   parameter int ACC_WIDTH         = 2*WIDTH+4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [WIDTH+2:0]               s_ix,
   input  logic [LOG2_NIBBLE_WIDTH-1:0]   s_sl,
   input  logic                           s_neg,
   input  logic                           s_last,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [ACC_WIDTH-1:0]           m_data,
   output logic [clog2(NUM_NIBBLES):0]    m_beats
);

   localparam int CNT_WIDTH = clog2(NUM_NIBBLES) + 1;

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_WIDTH-1:0]   nib_cnt_q, nib_cnt_d;
   logic [ACC_WIDTH-1:0]   term;
   logic                   accept;
   logic                   terminate;

   nibble_shifter #(
      .IX_WIDTH     (WIDTH+3),
      .IDX_WIDTH    (CNT_WIDTH),
      .SL_WIDTH     (LOG2_NIBBLE_WIDTH),
      .NIBBLE_WIDTH (NIBBLE_WIDTH),
      .OUT_WIDTH    (ACC_WIDTH)
   ) u_shifter (
      .ix      (s_ix),
      .nib_idx (nib_cnt_q),
      .sl      (s_sl),
      .shifted (term)
   );

   assign s_ready   = (state_q != ST_HOLD);
   assign accept    = s_valid && s_ready;
   assign terminate = s_last || (nib_cnt_q == CNT_WIDTH'(NUM_NIBBLES-1));

   // Flush beats everything; otherwise IDLE and ACCUM share the beat path.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      nib_cnt_d = nib_cnt_q;
      if (flush) begin
         state_d   = ST_IDLE;
         acc_d     = '0;
         nib_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (accept) begin
                  acc_d     = s_neg ? (acc_q - term) : (acc_q + term);
                  nib_cnt_d = nib_cnt_q + CNT_WIDTH'(1);
                  state_d   = terminate ? ST_HOLD : ST_ACCUM;
               end
            end
            ST_HOLD: begin
               if (m_ready) begin
                  state_d   = ST_IDLE;
                  acc_d     = '0;
                  nib_cnt_d = '0;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               acc_d     = '0;
               nib_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         nib_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         nib_cnt_q <= nib_cnt_d;
      end
   end

   assign m_valid = (state_q == ST_HOLD);
   assign m_data  = acc_q;
   assign m_beats = nib_cnt_q;

endmodule

// File: tb/tb_shift_acc_unit.sv
// Self-checking bench for shift_acc_unit: a table of single-beat operations,
// hand-written multi-cycle sequences and randomized operations against a sum model.
module tb_shift_acc_unit;
   import shift_acc_pkg::*;

   localparam int WIDTH   = 16;
   localparam int AW      = ACC_WIDTH_DEFAULT;
   localparam int IXW     = WIDTH + 3;
   localparam int BW      = 3;
   localparam logic [63:0] ACC_MASK = (64'd1 << AW) - 64'd1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            s_valid;
   logic            s_ready;
   logic [IXW-1:0]  s_ix;
   logic [1:0]      s_sl;
   logic            s_neg;
   logic            s_last;
   logic            m_valid;
   logic            m_ready;
   logic [AW-1:0]   m_data;
   logic [BW-1:0]   m_beats;

   int n_compared   = 0;
   int n_mismatched = 0;

   typedef struct {
      logic [IXW-1:0] ix;
      logic [1:0]     sl;
      logic           neg;
      logic [AW-1:0]  exp_data;
   } vec_t;

   vec_t vecs [6];

   shift_acc_unit #(
      .LOG2_WIDTH        (4),
      .LOG2_NIBBLE_WIDTH (2),
      .ACC_WIDTH         (AW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_ix    (s_ix),
      .s_sl    (s_sl),
      .s_neg   (s_neg),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_beats (m_beats)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      s_valid = 1'b0;
      s_ix    = '0;
      s_sl    = '0;
      s_neg   = 1'b0;
      s_last  = 1'b0;
   endtask

   // Offer one beat at a negedge; the next posedge accepts it.
   task automatic applyStimulus(input logic [IXW-1:0] ix, input logic [1:0] sl,
                                input logic neg, input logic last);
      s_valid = 1'b1;
      s_ix    = ix;
      s_sl    = sl;
      s_neg   = neg;
      s_last  = last;
      @(negedge clk);
      clearInputs();
   endtask

   task automatic expectResult(input string name, input logic [63:0] data, input int beats);
      checkOutput({name, ".m_valid"}, 64'(m_valid), 64'd1);
      checkOutput({name, ".m_data"},  64'(m_data),  data & ACC_MASK);
      checkOutput({name, ".m_beats"}, 64'(m_beats), 64'(beats));
      checkOutput({name, ".s_ready"}, 64'(s_ready), 64'd0);
   endtask

   task automatic retire(input string name);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      checkOutput({name, ".idle_m_valid"}, 64'(m_valid), 64'd0);
      checkOutput({name, ".idle_m_data"},  64'(m_data),  64'd0);
      checkOutput({name, ".idle_m_beats"}, 64'(m_beats), 64'd0);
      checkOutput({name, ".idle_s_ready"}, 64'(s_ready), 64'd1);
   endtask

   task automatic doReset();
      rst_n   = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b0;
      clearInputs();
      #3;
      checkOutput("reset.m_valid", 64'(m_valid), 64'd0);
      checkOutput("reset.m_data",  64'(m_data),  64'd0);
      checkOutput("reset.m_beats", 64'(m_beats), 64'd0);
      checkOutput("reset.s_ready", 64'(s_ready), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [63:0]    sum;
      logic [63:0]    term;
      logic [IXW-1:0] rix;
      logic [1:0]     rsl;
      logic           rneg;
      logic           rlast;
      int             nbeats;
      int             stalls;
      bit             forced;

      vecs[0] = '{19'd5,       2'd2, 1'b0, 36'd20};
      vecs[1] = '{19'd1,       2'd3, 1'b1, 36'hF_FFFF_FFF8};
      vecs[2] = '{19'h7FFFF,   2'd3, 1'b0, 36'h0_003F_FFF8};
      vecs[3] = '{19'd3,       2'd0, 1'b1, 36'hF_FFFF_FFFD};
      vecs[4] = '{19'd0,       2'd1, 1'b1, 36'd0};
      vecs[5] = '{19'h40000,   2'd0, 1'b1, 36'hF_FFFC_0000};

      doReset();

      // Single-beat operations go straight from IDLE to HOLD.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].ix, vecs[i].sl, vecs[i].neg, 1'b1);
         expectResult($sformatf("vec%0d", i), 64'(vecs[i].exp_data), 1);
         retire($sformatf("vec%0d", i));
      end

      applyStimulus(19'd5, 2'd1, 1'b0, 1'b0);
      checkOutput("two_beat.mid_m_valid", 64'(m_valid), 64'd0);
      applyStimulus(19'd3, 2'd0, 1'b0, 1'b1);
      expectResult("two_beat", 64'd58, 2);
      retire("two_beat");

      for (int b = 0; b < 4; b++) begin
         applyStimulus(19'd1, 2'd0, 1'b0, 1'b0);
      end
      expectResult("forced_term", 64'h1111, 4);
      retire("forced_term");

      for (int b = 0; b < 3; b++) begin
         applyStimulus(19'd0, 2'd0, 1'b0, 1'b0);
      end
      applyStimulus(19'd1, 2'd3, 1'b1, 1'b0);
      expectResult("subtract", 64'hF_FFFF_8000, 4);
      retire("subtract");

      // Backpressure, then a beat offered during the retire cycle must be ignored.
      applyStimulus(19'd2, 2'd1, 1'b0, 1'b1);
      expectResult("bp", 64'd4, 1);
      for (int c = 0; c < 5; c++) begin
         s_valid = 1'b1;
         s_ix    = 19'd9;
         s_last  = 1'b1;
         @(negedge clk);
         checkOutput($sformatf("bp.stall%0d_m_data", c), 64'(m_data), 64'd4);
         checkOutput($sformatf("bp.stall%0d_s_ready", c), 64'(s_ready), 64'd0);
         checkOutput($sformatf("bp.stall%0d_m_valid", c), 64'(m_valid), 64'd1);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      clearInputs();
      checkOutput("bp.bubble_m_valid", 64'(m_valid), 64'd0);
      checkOutput("bp.bubble_m_data",  64'(m_data),  64'd0);
      checkOutput("bp.bubble_s_ready", 64'(s_ready), 64'd1);

      // Flush mid-operation, with a competing last beat that must be dropped.
      applyStimulus(19'd6, 2'd1, 1'b0, 1'b0);
      applyStimulus(19'd2, 2'd2, 1'b0, 1'b0);
      flush   = 1'b1;
      s_valid = 1'b1;
      s_ix    = 19'd9;
      s_last  = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      clearInputs();
      checkOutput("flush.m_valid", 64'(m_valid), 64'd0);
      checkOutput("flush.m_data",  64'(m_data),  64'd0);
      checkOutput("flush.m_beats", 64'(m_beats), 64'd0);
      checkOutput("flush.s_ready", 64'(s_ready), 64'd1);
      applyStimulus(19'd7, 2'd0, 1'b0, 1'b1);
      expectResult("after_flush", 64'd7, 1);

      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flush_hold.m_valid", 64'(m_valid), 64'd0);
      checkOutput("flush_hold.m_data",  64'(m_data),  64'd0);

      // Asynchronous reset while holding a result.
      applyStimulus(19'd11, 2'd0, 1'b0, 1'b1);
      expectResult("pre_reset", 64'd11, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset.m_valid", 64'(m_valid), 64'd0);
      checkOutput("async_reset.m_data",  64'(m_data),  64'd0);
      checkOutput("async_reset.m_beats", 64'(m_beats), 64'd0);
      checkOutput("async_reset.s_ready", 64'(s_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset.m_valid", 64'(m_valid), 64'd0);

      // Randomized operations against a plain arithmetic sum model.
      for (int op = 0; op < 40; op++) begin
         nbeats = $urandom_range(1, 4);
         forced = (nbeats == 4) && ($urandom_range(0, 1) == 1);
         sum    = 64'd0;
         for (int b = 0; b < nbeats; b++) begin
            rix   = IXW'($urandom);
            rsl   = 2'($urandom_range(0, 3));
            rneg  = 1'($urandom_range(0, 1));
            rlast = (b == nbeats - 1) && !forced;
            term  = 64'(rix) << (4 * b + int'(rsl));
            sum   = rneg ? (sum - term) : (sum + term);
            applyStimulus(rix, rsl, rneg, rlast);
         end
         expectResult($sformatf("rand%0d", op), sum, nbeats);
         stalls = $urandom_range(0, 3);
         for (int c = 0; c < stalls; c++) begin
            s_valid = 1'b1;
            s_ix    = IXW'($urandom);
            @(negedge clk);
            clearInputs();
            checkOutput($sformatf("rand%0d.stall_m_data", op), 64'(m_data), sum & ACC_MASK);
         end
         retire($sformatf("rand%0d", op));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
